// File: rtl/udp_pkg.sv
// Shared types and constants for the UDP transmit arbitration path.
package udp_pkg;

    localparam int unsigned UDP_PORT_W = 16;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_HDR     = 2'd1,
        ARB_PAYLOAD = 2'd2
    } arb_state_t;

endpackage

// File: rtl/udp_tx_arbiter_rr.sv
// Combinational round-robin picker: first set request at or after ptr, with wrap-around.
module rr_arbiter #(
    parameter  int unsigned N  = 4,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt_onehot,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_valid
);

    logic [2*N-1:0] w_dbl;
    logic [N-1:0]   w_rot;
    logic [IW-1:0]  w_off;
    logic [IW:0]    w_sum;

    // Rotating a doubled copy puts the request at ptr into bit 0.
    assign w_dbl = {req, req} >> ptr;
    assign w_rot = w_dbl[N-1:0];

    always_comb begin
        w_off     = '0;
        gnt_valid = 1'b0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off     = IW'(i);
                gnt_valid = 1'b1;
            end
        end
    end

    assign w_sum      = {1'b0, ptr} + {1'b0, w_off};
    assign gnt_idx    = (w_sum >= (IW+1)'(N)) ? IW'(w_sum - (IW+1)'(N)) : IW'(w_sum);
    assign gnt_onehot = gnt_valid ? (N'(1) << gnt_idx) : '0;

endmodule

// File: rtl/udp_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one udp_tx header + payload path among requesters.
module udp_tx_arbiter
    import udp_pkg::*;
#(
    parameter  int unsigned NUM_PORTS      = 4,
    parameter  int unsigned AXI_DATA_WIDTH = 8,
    localparam int unsigned GW             = $clog2(NUM_PORTS)
) (
    input  logic                                i_clk,
    input  logic                                i_reset,
    input  logic [NUM_PORTS-1:0]                s_udp_hdr_tvalid,
    output logic [NUM_PORTS-1:0]                s_udp_hdr_trdy,
    input  logic [UDP_PORT_W*NUM_PORTS-1:0]     s_udp_src_port,
    input  logic [UDP_PORT_W*NUM_PORTS-1:0]     s_udp_dst_port,
    input  logic [AXI_DATA_WIDTH*NUM_PORTS-1:0] s_tx_axis_tdata,
    input  logic [NUM_PORTS-1:0]                s_tx_axis_tvalid,
    input  logic [NUM_PORTS-1:0]                s_tx_axis_tlast,
    output logic [NUM_PORTS-1:0]                s_tx_axis_trdy,
    output logic                                m_udp_hdr_tvalid,
    input  logic                                m_udp_hdr_trdy,
    output logic [UDP_PORT_W-1:0]               m_udp_src_port,
    output logic [UDP_PORT_W-1:0]               m_udp_dst_port,
    output logic [AXI_DATA_WIDTH-1:0]           m_tx_axis_tdata,
    output logic                                m_tx_axis_tvalid,
    output logic                                m_tx_axis_tlast,
    input  logic                                m_tx_axis_trdy,
    output logic [GW-1:0]                       o_grant_idx,
    output logic                                o_busy
);

    arb_state_t r_state, w_next_state;
    logic [GW-1:0]         r_rr_ptr, w_rr_ptr_next;
    logic [GW-1:0]         r_grant, w_grant_next;
    logic                  r_hdr_tvalid, w_hdr_tvalid_next;
    logic [UDP_PORT_W-1:0] r_src, w_src_next;
    logic [UDP_PORT_W-1:0] r_dst, w_dst_next;

    logic [NUM_PORTS-1:0]      w_gnt_onehot;
    logic [GW-1:0]             w_gnt_idx;
    logic                      w_gnt_valid;
    logic [UDP_PORT_W-1:0]     w_gnt_src;
    logic [UDP_PORT_W-1:0]     w_gnt_dst;
    logic [AXI_DATA_WIDTH-1:0] w_sel_tdata;
    logic                      w_sel_tvalid;
    logic                      w_sel_tlast;

    rr_arbiter #(
        .N (NUM_PORTS)
    ) u_rr (
        .req        (s_udp_hdr_tvalid),
        .ptr        (r_rr_ptr),
        .gnt_onehot (w_gnt_onehot),
        .gnt_idx    (w_gnt_idx),
        .gnt_valid  (w_gnt_valid)
    );

    assign w_gnt_src    = s_udp_src_port[w_gnt_idx*UDP_PORT_W +: UDP_PORT_W];
    assign w_gnt_dst    = s_udp_dst_port[w_gnt_idx*UDP_PORT_W +: UDP_PORT_W];
    assign w_sel_tdata  = s_tx_axis_tdata[r_grant*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
    assign w_sel_tvalid = s_tx_axis_tvalid[r_grant];
    assign w_sel_tlast  = s_tx_axis_tlast[r_grant];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= ARB_IDLE;
            r_rr_ptr     <= '0;
            r_grant      <= '0;
            r_hdr_tvalid <= 1'b0;
            r_src        <= '0;
            r_dst        <= '0;
        end else begin
            r_state      <= w_next_state;
            r_rr_ptr     <= w_rr_ptr_next;
            r_grant      <= w_grant_next;
            r_hdr_tvalid <= w_hdr_tvalid_next;
            r_src        <= w_src_next;
            r_dst        <= w_dst_next;
        end
    end

    always_comb begin
        w_next_state      = r_state;
        w_rr_ptr_next     = r_rr_ptr;
        w_grant_next      = r_grant;
        w_hdr_tvalid_next = r_hdr_tvalid;
        w_src_next        = r_src;
        w_dst_next        = r_dst;
        s_udp_hdr_trdy    = '0;
        s_tx_axis_trdy    = '0;
        m_tx_axis_tdata   = '0;
        m_tx_axis_tvalid  = 1'b0;
        m_tx_axis_tlast   = 1'b0;

        unique case (r_state)
            ARB_IDLE: begin
                // Accepting the header in the arbitration cycle lets the header be latched at once.
                s_udp_hdr_trdy = w_gnt_onehot;
                if (w_gnt_valid) begin
                    w_next_state      = ARB_HDR;
                    w_grant_next      = w_gnt_idx;
                    w_hdr_tvalid_next = 1'b1;
                    w_src_next        = w_gnt_src;
                    w_dst_next        = w_gnt_dst;
                end
            end
            ARB_HDR: begin
                if (m_udp_hdr_trdy) begin
                    w_next_state      = ARB_PAYLOAD;
                    w_hdr_tvalid_next = 1'b0;
                end
            end
            ARB_PAYLOAD: begin
                m_tx_axis_tdata         = w_sel_tdata;
                m_tx_axis_tvalid        = w_sel_tvalid;
                m_tx_axis_tlast         = w_sel_tlast;
                s_tx_axis_trdy[r_grant] = m_tx_axis_trdy;
                if (w_sel_tvalid && m_tx_axis_trdy && w_sel_tlast) begin
                    w_next_state  = ARB_IDLE;
                    w_rr_ptr_next = (r_grant == GW'(NUM_PORTS - 1)) ? '0 : r_grant + GW'(1);
                end
            end
            default: w_next_state = ARB_IDLE;
        endcase
    end

    assign m_udp_hdr_tvalid = r_hdr_tvalid;
    assign m_udp_src_port   = r_src;
    assign m_udp_dst_port   = r_dst;
    assign o_grant_idx      = r_grant;
    assign o_busy           = (r_state != ARB_IDLE);

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Bench for udp_tx_arbiter: per-port packet sources and a round-robin packet-level reference model.
module tb_udp_tx_arbiter;

    localparam int NP = 4;
    localparam int DW = 8;
    localparam int PH_IDLE = 0;
    localparam int PH_HDR  = 1;
    localparam int PH_PAY  = 2;

    logic            clk = 1'b0;
    logic            i_reset;
    logic [NP-1:0]   s_udp_hdr_tvalid;
    logic [NP-1:0]   s_udp_hdr_trdy;
    logic [16*NP-1:0] s_udp_src_port;
    logic [16*NP-1:0] s_udp_dst_port;
    logic [DW*NP-1:0] s_tx_axis_tdata;
    logic [NP-1:0]   s_tx_axis_tvalid;
    logic [NP-1:0]   s_tx_axis_tlast;
    logic [NP-1:0]   s_tx_axis_trdy;
    logic            m_udp_hdr_tvalid;
    logic            m_udp_hdr_trdy;
    logic [15:0]     m_udp_src_port;
    logic [15:0]     m_udp_dst_port;
    logic [DW-1:0]   m_tx_axis_tdata;
    logic            m_tx_axis_tvalid;
    logic            m_tx_axis_tlast;
    logic            m_tx_axis_trdy;
    logic [1:0]      o_grant_idx;
    logic            o_busy;

    always #5 clk = ~clk;

    udp_tx_arbiter #(.NUM_PORTS(NP), .AXI_DATA_WIDTH(DW)) dut (
        .i_clk(clk), .i_reset(i_reset),
        .s_udp_hdr_tvalid(s_udp_hdr_tvalid), .s_udp_hdr_trdy(s_udp_hdr_trdy),
        .s_udp_src_port(s_udp_src_port), .s_udp_dst_port(s_udp_dst_port),
        .s_tx_axis_tdata(s_tx_axis_tdata), .s_tx_axis_tvalid(s_tx_axis_tvalid),
        .s_tx_axis_tlast(s_tx_axis_tlast), .s_tx_axis_trdy(s_tx_axis_trdy),
        .m_udp_hdr_tvalid(m_udp_hdr_tvalid), .m_udp_hdr_trdy(m_udp_hdr_trdy),
        .m_udp_src_port(m_udp_src_port), .m_udp_dst_port(m_udp_dst_port),
        .m_tx_axis_tdata(m_tx_axis_tdata), .m_tx_axis_tvalid(m_tx_axis_tvalid),
        .m_tx_axis_tlast(m_tx_axis_tlast), .m_tx_axis_trdy(m_tx_axis_trdy),
        .o_grant_idx(o_grant_idx), .o_busy(o_busy)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: packet phase, round-robin pointer, current grant.
    int phase, model_ptr, model_g;
    // Per-port source state.
    int          pkts_left[NP];
    logic [15:0] hsrc[NP];
    logic [15:0] hdst[NP];
    logic [7:0]  pay[NP][16];
    int          plen[NP];
    int          beat[NP];
    bit          in_pay[NP];
    bit          junk[NP];
    // Sink behaviour knobs.
    int hdr_delay, hdr_delay_fixed, hdr_cnt, hdr_cycles, beats_rx, fixed_len, tx_mode, vprob;
    bit hdr_rand, tx_tog;
    int order[$];

    task automatic new_pkt(input int i);
        hsrc[i] = 16'($urandom);
        hdst[i] = 16'($urandom);
        plen[i] = (fixed_len > 0) ? fixed_len : int'($urandom_range(1, 8));
        for (int b = 0; b < 16; b++) pay[i][b] = 8'($urandom);
    endtask

    task automatic clear_bench();
        phase = PH_IDLE; model_ptr = 0; model_g = 0;
        hdr_delay = 0; hdr_delay_fixed = 0; hdr_cnt = 0; hdr_cycles = 0; beats_rx = 0;
        fixed_len = 0; tx_mode = 0; vprob = 100; hdr_rand = 0; tx_tog = 0;
        order.delete();
        for (int i = 0; i < NP; i++) begin
            pkts_left[i] = 0; in_pay[i] = 0; junk[i] = 0; beat[i] = 0;
            new_pkt(i);
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < NP; i++) begin
            s_udp_hdr_tvalid[i] = !junk[i] && !in_pay[i] && (pkts_left[i] > 0);
            s_udp_src_port[16*i +: 16] = hsrc[i];
            s_udp_dst_port[16*i +: 16] = hdst[i];
            if (junk[i]) begin
                s_tx_axis_tvalid[i] = 1'b1;
                s_tx_axis_tlast[i]  = 1'b1;
                s_tx_axis_tdata[DW*i +: DW] = 8'($urandom);
            end else if (in_pay[i]) begin
                s_tx_axis_tvalid[i] = (int'($urandom_range(0, 99)) < vprob);
                s_tx_axis_tlast[i]  = (beat[i] == plen[i] - 1);
                s_tx_axis_tdata[DW*i +: DW] = pay[i][beat[i]];
            end else begin
                s_tx_axis_tvalid[i] = 1'b0;
                s_tx_axis_tlast[i]  = 1'b0;
                s_tx_axis_tdata[DW*i +: DW] = 8'($urandom);
            end
        end
        m_udp_hdr_trdy = (phase == PH_HDR) ? (hdr_cnt >= hdr_delay) : 1'($urandom);
        if (tx_mode == 0) m_tx_axis_trdy = 1'b1;
        else if (tx_mode == 1) begin tx_tog = !tx_tog; m_tx_axis_trdy = tx_tog; end
        else m_tx_axis_trdy = 1'($urandom);
    endtask

    // Compares every DUT output against the model for the current cycle, then advances the model.
    task automatic monitor();
        logic [NP-1:0] reqs, exp1h, exp_trdy;
        int w, g;
        checks++;
        if (o_grant_idx !== 2'(model_g)) begin
            errors++; $display("FAIL grant_idx: got %0d expected %0d", o_grant_idx, model_g);
        end
        checks++;
        if (o_busy !== (phase != PH_IDLE)) begin
            errors++; $display("FAIL busy: got %b phase %0d", o_busy, phase);
        end
        if (phase == PH_IDLE) begin
            reqs = s_udp_hdr_tvalid; w = -1; exp1h = '0;
            for (int k = 0; k < NP; k++)
                if (w < 0 && reqs[(model_ptr + k) % NP]) w = (model_ptr + k) % NP;
            if (w >= 0) exp1h[w] = 1'b1;
            for (int i = 0; i < NP; i++) if (s_udp_hdr_trdy[i]) order.push_back(i);
            checks++;
            if (s_udp_hdr_trdy !== exp1h) begin
                errors++; $display("FAIL hdr_trdy: got %b expected %b (ptr %0d)", s_udp_hdr_trdy, exp1h, model_ptr);
            end
            checks++;
            if (m_udp_hdr_tvalid !== 1'b0 || m_tx_axis_tvalid !== 1'b0 || s_tx_axis_trdy !== '0) begin
                errors++; $display("FAIL idle_outputs: hv %b tv %b trdy %b expected 0 0 0", m_udp_hdr_tvalid, m_tx_axis_tvalid, s_tx_axis_trdy);
            end
            if (w >= 0) begin
                model_g = w; phase = PH_HDR; hdr_cnt = 0;
                hdr_delay = hdr_rand ? int'($urandom_range(0, 3)) : hdr_delay_fixed;
                in_pay[w] = 1'b1; beat[w] = 0;
            end
        end else if (phase == PH_HDR) begin
            hdr_cycles++;
            checks++;
            if (m_udp_hdr_tvalid !== 1'b1 || m_udp_src_port !== hsrc[model_g] || m_udp_dst_port !== hdst[model_g]) begin
                errors++; $display("FAIL hdr_out: got v%b %h/%h expected v1 %h/%h", m_udp_hdr_tvalid, m_udp_src_port, m_udp_dst_port, hsrc[model_g], hdst[model_g]);
            end
            checks++;
            if (s_udp_hdr_trdy !== '0 || s_tx_axis_trdy !== '0 || m_tx_axis_tvalid !== 1'b0) begin
                errors++; $display("FAIL hdr_quiet: htrdy %b ptrdy %b tv %b expected 0 0 0", s_udp_hdr_trdy, s_tx_axis_trdy, m_tx_axis_tvalid);
            end
            if (m_udp_hdr_trdy) phase = PH_PAY; else hdr_cnt++;
        end else begin
            g = model_g; exp_trdy = '0; exp_trdy[g] = m_tx_axis_trdy;
            checks++;
            if (s_tx_axis_trdy !== exp_trdy || s_udp_hdr_trdy !== '0 || m_udp_hdr_tvalid !== 1'b0) begin
                errors++; $display("FAIL pay_ctrl: ptrdy %b expected %b htrdy %b hv %b", s_tx_axis_trdy, exp_trdy, s_udp_hdr_trdy, m_udp_hdr_tvalid);
            end
            checks++;
            if (m_tx_axis_tvalid !== s_tx_axis_tvalid[g]) begin
                errors++; $display("FAIL pay_valid: got %b expected %b", m_tx_axis_tvalid, s_tx_axis_tvalid[g]);
            end
            if (s_tx_axis_tvalid[g]) begin
                checks++;
                if (m_tx_axis_tdata !== pay[g][beat[g]] || m_tx_axis_tlast !== (beat[g] == plen[g] - 1)) begin
                    errors++; $display("FAIL pay_beat: port %0d beat %0d got %h/%b expected %h/%b", g, beat[g], m_tx_axis_tdata, m_tx_axis_tlast, pay[g][beat[g]], beat[g] == plen[g] - 1);
                end
            end
            if (s_tx_axis_tvalid[g] && m_tx_axis_trdy) begin
                beats_rx++;
                if (beat[g] == plen[g] - 1) begin
                    phase = PH_IDLE; model_ptr = (g + 1) % NP;
                    pkts_left[g]--; in_pay[g] = 1'b0; new_pkt(g);
                end else beat[g]++;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        drive_inputs();
    endtask

    function automatic bit all_done();
        bit d = (phase == PH_IDLE);
        for (int i = 0; i < NP; i++) if (!junk[i] && pkts_left[i] > 0) d = 1'b0;
        return d;
    endfunction

    task automatic run(input int maxc);
        int c = 0;
        while (!all_done() && c < maxc) begin step(); c++; end
        checks++;
        if (c >= maxc) begin errors++; $display("FAIL timeout: %0d cycles, phase %0d", c, phase); end
        step();
    endtask

    task automatic reset_dut();
        @(posedge clk); #1;
        i_reset = 1'b1;
        clear_bench();
        s_udp_hdr_tvalid = '0; s_udp_src_port = '0; s_udp_dst_port = '0;
        s_tx_axis_tdata = '0; s_tx_axis_tvalid = '0; s_tx_axis_tlast = '0;
        m_udp_hdr_trdy = 1'b0; m_tx_axis_trdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        i_reset = 1'b0;
        drive_inputs();
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        i_reset = 1'b1;
        clear_bench();
        s_udp_hdr_tvalid = '0; s_tx_axis_tvalid = '1; s_tx_axis_tlast = '1;
        m_udp_hdr_trdy = 1'b1; m_tx_axis_trdy = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (m_udp_hdr_tvalid !== 1'b0 || m_udp_src_port !== 16'h0 || m_udp_dst_port !== 16'h0) begin
            errors++; $display("FAIL reset_hdr: got %b %h %h expected 0 0000 0000", m_udp_hdr_tvalid, m_udp_src_port, m_udp_dst_port);
        end
        checks++;
        if (s_udp_hdr_trdy !== '0 || s_tx_axis_trdy !== '0 || m_tx_axis_tvalid !== 1'b0 || m_tx_axis_tlast !== 1'b0) begin
            errors++; $display("FAIL reset_strm: htrdy %b ptrdy %b tv %b tl %b expected all 0", s_udp_hdr_trdy, s_tx_axis_trdy, m_tx_axis_tvalid, m_tx_axis_tlast);
        end
        checks++;
        if (o_busy !== 1'b0 || o_grant_idx !== 2'd0) begin
            errors++; $display("FAIL reset_status: busy %b grant %0d expected 0 0", o_busy, o_grant_idx);
        end
        @(posedge clk); #1;
        i_reset = 1'b0;
        s_tx_axis_tvalid = '0; s_tx_axis_tlast = '0;
        drive_inputs();
    endtask

    task automatic test_single();
        reset_dut();
        hsrc[1] = 16'h1234; hdst[1] = 16'h0050; plen[1] = 3;
        pay[1][0] = 8'hAA; pay[1][1] = 8'hBB; pay[1][2] = 8'hCC;
        pkts_left[1] = 1;
        drive_inputs();
        run(100);
        checks++;
        if (order.size() != 1 || order[0] != 1) begin
            errors++; $display("FAIL single_order: got %p expected '{1}", order);
        end
        checks++;
        if (beats_rx != 3 || o_grant_idx !== 2'd1) begin
            errors++; $display("FAIL single_beats: got %0d beats grant %0d expected 3 beats grant 1", beats_rx, o_grant_idx);
        end
    endtask

    task automatic test_round_robin();
        int exp_o[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        reset_dut();
        fixed_len = 2;
        for (int i = 0; i < NP; i++) begin pkts_left[i] = 2; new_pkt(i); end
        drive_inputs();
        run(300);
        checks++;
        if (order.size() != 8) begin
            errors++; $display("FAIL rr_count: got %0d grants expected 8", order.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                checks++;
                if (order[k] != exp_o[k]) begin
                    errors++; $display("FAIL rr_order[%0d]: got %0d expected %0d", k, order[k], exp_o[k]);
                end
            end
        end
    endtask

    task automatic test_ptr_wrap();
        int exp_o[4] = '{1, 3, 0, 1};
        reset_dut();
        pkts_left[1] = 1;
        drive_inputs();
        run(100);
        pkts_left[0] = 1; pkts_left[1] = 1; pkts_left[3] = 1;
        drive_inputs();
        run(300);
        checks++;
        if (order.size() != 4) begin
            errors++; $display("FAIL wrap_count: got %0d grants expected 4", order.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (order[k] != exp_o[k]) begin
                    errors++; $display("FAIL wrap_order[%0d]: got %0d expected %0d", k, order[k], exp_o[k]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        reset_dut();
        fixed_len = 6; hdr_delay_fixed = 5; tx_mode = 1;
        new_pkt(2); pkts_left[2] = 1;
        drive_inputs();
        run(200);
        checks++;
        if (hdr_cycles != 6) begin
            errors++; $display("FAIL bp_hdr_cycles: got %0d expected 6", hdr_cycles);
        end
        checks++;
        if (beats_rx != 6 || order.size() != 1) begin
            errors++; $display("FAIL bp_beats: got %0d beats %0d grants expected 6 and 1", beats_rx, order.size());
        end
    endtask

    task automatic test_ignore_nongranted();
        reset_dut();
        fixed_len = 4; junk[2] = 1'b1;
        new_pkt(0); pkts_left[0] = 1;
        drive_inputs();
        run(100);
        checks++;
        if (beats_rx != 4 || order.size() != 1 || order[0] != 0) begin
            errors++; $display("FAIL ignore: got %0d beats %p expected 4 beats '{0}", beats_rx, order);
        end
    endtask

    task automatic test_reset_mid();
        int c = 0;
        int exp_o[2] = '{1, 3};
        reset_dut();
        fixed_len = 2; new_pkt(1); pkts_left[1] = 1;
        drive_inputs();
        run(100);
        fixed_len = 5; new_pkt(2); pkts_left[2] = 1;
        drive_inputs();
        while (!(phase == PH_PAY && beat[2] == 2) && c < 50) begin step(); c++; end
        checks++;
        if (c >= 50) begin errors++; $display("FAIL midreset_reach: phase %0d beat %0d", phase, beat[2]); end
        i_reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (o_busy !== 1'b0 || m_tx_axis_tvalid !== 1'b0 || m_tx_axis_tlast !== 1'b0 || s_tx_axis_trdy !== '0) begin
            errors++; $display("FAIL midreset_strm: busy %b tv %b tl %b ptrdy %b expected all 0", o_busy, m_tx_axis_tvalid, m_tx_axis_tlast, s_tx_axis_trdy);
        end
        checks++;
        if (o_grant_idx !== 2'd0 || m_udp_hdr_tvalid !== 1'b0 || m_udp_src_port !== 16'h0 || m_udp_dst_port !== 16'h0) begin
            errors++; $display("FAIL midreset_hdr: grant %0d hv %b %h %h expected 0 0 0000 0000", o_grant_idx, m_udp_hdr_tvalid, m_udp_src_port, m_udp_dst_port);
        end
        @(posedge clk); #1;
        i_reset = 1'b0;
        clear_bench();
        pkts_left[1] = 1; pkts_left[3] = 1;
        drive_inputs();
        run(200);
        checks++;
        if (order.size() != 2 || order[0] != exp_o[0] || order[1] != exp_o[1]) begin
            errors++; $display("FAIL midreset_order: got %p expected '{1, 3}", order);
        end
    endtask

    task automatic test_random();
        int total = 0;
        reset_dut();
        hdr_rand = 1'b1; tx_mode = 2; vprob = 70;
        for (int i = 0; i < NP; i++) begin
            pkts_left[i] = int'($urandom_range(1, 5));
            total += pkts_left[i];
        end
        drive_inputs();
        run(4000);
        checks++;
        if (order.size() != total) begin
            errors++; $display("FAIL random_count: got %0d grants expected %0d", order.size(), total);
        end
    endtask

    initial begin
        i_reset = 1'b1;
        clear_bench();
        s_udp_hdr_tvalid = '0; s_udp_src_port = '0; s_udp_dst_port = '0;
        s_tx_axis_tdata = '0; s_tx_axis_tvalid = '0; s_tx_axis_tlast = '0;
        m_udp_hdr_trdy = 1'b0; m_tx_axis_trdy = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_ptr_wrap();
        test_backpressure();
        test_ignore_nongranted();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/udp_tx_arbiter.md
Name: udp_tx_arbiter

Overview:
- Shares one udp_tx encapsulation datapath between NUM_PORTS upstream requesters. Each requester presents a UDP header (src/dst port) plus an AXI-Stream payload.
- Grants whole packets using round-robin arbitration. Presents the winner's header on the single header port of the downstream encapsulator, then passes its payload through until tlast.
- Sits between the application/socket layer and udp_tx.

Parameters:
- NUM_PORTS, 4, number of requesters (2..8).
- AXI_DATA_WIDTH, 8, payload tdata width.

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  synchronous, active-high reset.
- s_udp_hdr_tvalid  in  NUM_PORTS  per-requester header valid; also acts as the arbitration request.
- s_udp_hdr_trdy  out  NUM_PORTS  per-requester header accept.
- s_udp_src_port  in  16*NUM_PORTS  flattened source ports; port i at [16*i+:16].
- s_udp_dst_port  in  16*NUM_PORTS  flattened destination ports.
- s_tx_axis_tdata  in  AXI_DATA_WIDTH*NUM_PORTS  flattened payload data.
- s_tx_axis_tvalid  in  NUM_PORTS  payload valid.
- s_tx_axis_tlast  in  NUM_PORTS  payload last.
- s_tx_axis_trdy  out  NUM_PORTS  payload ready.
- m_udp_hdr_tvalid  out  1  header valid to the encapsulator.
- m_udp_hdr_trdy  in  1  header ready from the encapsulator.
- m_udp_src_port  out  16  granted source port.
- m_udp_dst_port  out  16  granted destination port.
- m_tx_axis_tdata  out  AXI_DATA_WIDTH  payload data to the encapsulator.
- m_tx_axis_tvalid  out  1  payload valid.
- m_tx_axis_tlast  out  1  payload last.
- m_tx_axis_trdy  in  1  payload ready.
- o_grant_idx  out  $clog2(NUM_PORTS)  index of the current or last grant.
- o_busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (i_reset=1 at a clock edge):
  - state=IDLE, rr_ptr=0, grant=0.
  - m_udp_hdr_tvalid=0; m_udp_src_port and m_udp_dst_port = 0.
  - All s_*_trdy outputs 0; m_tx_axis_tvalid=0, m_tx_axis_tlast=0; o_busy=0; o_grant_idx=0.
  - Reset mid-packet abandons the packet immediately. The downstream stream is truncated with no tlast; the system must also reset the encapsulator.
- States:
  - IDLE: arbitrate. If no s_udp_hdr_tvalid bit is set, stay in IDLE.
  - HDR: present the latched header.
  - PAYLOAD: pass the granted payload through.
- IDLE arbitration:
  - Winner g is the first set bit of s_udp_hdr_tvalid, searching from rr_ptr upward with wrap-around.
  - In the same cycle, s_udp_hdr_trdy[g]=1 (combinational, IDLE only, one-hot or zero). This accepts the header.
  - Next edge: latch the winner's src/dst into m_udp_src_port/m_udp_dst_port, grant<=g, m_udp_hdr_tvalid<=1, state<=HDR.
- HDR:
  - Hold m_udp_hdr_tvalid and the header fields stable until m_udp_hdr_trdy=1.
  - On that edge: m_udp_hdr_tvalid<=0, state<=PAYLOAD.
  - Payload is not passed during HDR: all s_tx_axis_trdy=0, m_tx_axis_tvalid=0.
- PAYLOAD (zero-latency combinational pass-through from granted port):
  - m_tx_axis_tdata = s_tx_axis_tdata[grant].
  - m_tx_axis_tvalid = s_tx_axis_tvalid[grant].
  - m_tx_axis_tlast = s_tx_axis_tlast[grant].
  - s_tx_axis_trdy[grant] = m_tx_axis_trdy. All other trdy bits are 0.
- End of packet: on the edge where m_tx_axis_tvalid & m_tx_axis_trdy & m_tx_axis_tlast, set state<=IDLE and rr_ptr<=(grant+1) mod NUM_PORTS.
- Inter-packet gap: at least one IDLE cycle between packets. Max header throughput is one grant per packet plus 2 cycles.
- Non-granted requesters:
  - Their payload is stalled (trdy=0); their tlast is ignored.
  - Raising or dropping header valid while not granted has no effect.
- Simultaneous requests: lowest index at or after rr_ptr wins.
  - Example, NUM_PORTS=4, rr_ptr=2, requests 4'b1011: grant 3.
  - rr_ptr wraps from NUM_PORTS-1 to 0.
- A single requester with a continuous request is re-granted every packet (no starvation check needed). Any other waiting requester is served within NUM_PORTS-1 packets.
- Zero-length payload is not supported: the requester must send at least one beat with tlast.
- o_grant_idx = grant register. It holds its value through IDLE.

Decomposition:
- Shared package udp_pkg:
  - arb_state_t enum (ARB_IDLE, ARB_HDR, ARB_PAYLOAD).
  - UDP_PORT_W=16 constant.
- Sub-module rr_arbiter:
  - Parameter N.
  - Inputs: req[N], ptr.
  - Outputs: gnt_onehot, gnt_idx, gnt_valid.
  - Purely combinational, using a double-width rotate-and-priority-encode.

Test Plan:
- Reset then single request: port 1 header src=0x1234, dst=0x0050, 3-byte payload AA BB CC. Expect s_udp_hdr_trdy=4'b0010 for one cycle; m_udp_src_port=0x1234 and m_udp_dst_port=0x0050 with tvalid until hdr trdy; then AA BB CC with tlast on CC; rr_ptr=2; o_busy low one cycle later.
- All four ports request continuously, 2-byte payloads each. Expect grant order 0,1,2,3,0 and each payload arriving intact.
- Requests 4'b1011 with rr_ptr=2. Expect grant 3 first, then 0, then 1.
- Backpressure: m_udp_hdr_trdy low 5 cycles, then m_tx_axis_trdy toggling 1010. Expect the header held stable, no payload beats lost or duplicated, and s_tx_axis_trdy[grant] mirroring m_tx_axis_trdy.
- Port 2 asserts payload tvalid and tlast while port 0 is granted. Expect s_tx_axis_trdy[2]=0 throughout and no effect on the port 0 packet end.
- Assert i_reset in PAYLOAD after 2 of 5 beats. Expect next cycle: all outputs at reset values, state IDLE, rr_ptr=0; a fresh request on port 3 is then granted normally.
